// File: rtl/mdu_defs_pkg.sv
// Shared MDU opcode definitions used by the controller, decoder and hazard unit.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled with MDU_MADD_EN.
package mdu_defs;

    localparam int MDU_OPW = 4;

    localparam logic [MDU_OPW-1:0] MDU_NOP   = 4'b0000;
    localparam logic [MDU_OPW-1:0] MDU_MULT  = 4'b0001;
    localparam logic [MDU_OPW-1:0] MDU_MULTU = 4'b0010;
    localparam logic [MDU_OPW-1:0] MDU_DIV   = 4'b0011;
    localparam logic [MDU_OPW-1:0] MDU_DIVU  = 4'b0100;
    localparam logic [MDU_OPW-1:0] MDU_MTHI  = 4'b0101;
    localparam logic [MDU_OPW-1:0] MDU_MTLO  = 4'b0110;
    localparam logic [MDU_OPW-1:0] MDU_MFHI  = 4'b0111;
    localparam logic [MDU_OPW-1:0] MDU_MFLO  = 4'b1000;
    localparam logic [MDU_OPW-1:0] MDU_MADD  = 4'b1001;
    localparam logic [MDU_OPW-1:0] MDU_MADDU = 4'b1010;
    localparam logic [MDU_OPW-1:0] MDU_MSUB  = 4'b1011;
    localparam logic [MDU_OPW-1:0] MDU_MSUBU = 4'b1100;

    // Multiply-class ops share MULT_CYCLES latency; accumulate ops only exist when enabled.
    function automatic logic mdu_is_mult(input logic [MDU_OPW-1:0] op);
        logic r;
        r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
                 (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic mdu_is_div(input logic [MDU_OPW-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational 64-bit result generator for multiply, divide and accumulate ops.
// Accumulate ops are generated only when MDU_MADD_EN is defined.
module mdu_core
    import mdu_defs::*;
(
    input  logic [MDU_OPW-1:0] i_op,
    input  logic [31:0]        i_a,
    input  logic [31:0]        i_b,
    input  logic [31:0]        i_hi,
    input  logic [31:0]        i_lo,
    output logic [31:0]        o_new_hi,
    output logic [31:0]        o_new_lo,
    output logic               o_we
);

    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic        w_sdiv;
    logic        w_bzero;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_qs;
    logic [31:0] w_rs;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_umul = {32'b0, i_a} * {32'b0, i_b};

    // One unsigned divider on magnitudes serves both DIV and DIVU.
    assign w_sdiv  = (i_op == MDU_DIV);
    assign w_bzero = (i_b == 32'b0);
    assign w_dvd   = (w_sdiv && i_a[31]) ? -i_a : i_a;
    assign w_dvs   = (w_sdiv && i_b[31]) ? -i_b : i_b;
    assign w_q     = w_bzero ? 32'b0 : w_dvd / w_dvs;
    assign w_r     = w_bzero ? 32'b0 : w_dvd % w_dvs;
    assign w_qs    = (w_sdiv && (i_a[31] ^ i_b[31])) ? -w_q : w_q;
    assign w_rs    = (w_sdiv && i_a[31]) ? -w_r : w_r;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc;
    assign w_acc = {i_hi, i_lo};
`endif

    always_comb begin
        o_new_hi = i_hi;
        o_new_lo = i_lo;
        o_we     = 1'b0;
        case (i_op)
            MDU_MULT:  begin {o_new_hi, o_new_lo} = w_smul; o_we = 1'b1; end
            MDU_MULTU: begin {o_new_hi, o_new_lo} = w_umul; o_we = 1'b1; end
            MDU_DIV, MDU_DIVU: begin
                if (!w_bzero) begin
                    o_new_hi = w_rs;
                    o_new_lo = w_qs;
                    o_we     = 1'b1;
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  begin {o_new_hi, o_new_lo} = w_acc + w_smul; o_we = 1'b1; end
            MDU_MADDU: begin {o_new_hi, o_new_lo} = w_acc + w_umul; o_we = 1'b1; end
            MDU_MSUB:  begin {o_new_hi, o_new_lo} = w_acc - w_smul; o_we = 1'b1; end
            MDU_MSUBU: begin {o_new_hi, o_new_lo} = w_acc - w_umul; o_we = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div controller: FSM, latency counter, operand latches, HI/LO and read mux.
// MDU_MADD_EN adds the accumulate ops (decoded in mdu_defs, computed in mdu_core).
module mdu_ctrl
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MDU_OPW-1:0] mdu_op,
    input  logic [31:0]        A,
    input  logic [31:0]        B,
    output logic               busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo,
    output logic [31:0]        rd_data
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [MDU_OPW-1:0] r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_is_mult;
    logic               w_is_div;
    logic [CW-1:0]      w_ncyc;
    logic [31:0]        w_new_hi;
    logic [31:0]        w_new_lo;
    logic               w_we;

    assign w_is_mult = mdu_is_mult(mdu_op);
    assign w_is_div  = mdu_is_div(mdu_op);
    assign w_ncyc    = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    // Accumulate ops read HI/LO as they stand at commit time.
    mdu_core u_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_new_hi (w_new_hi),
        .o_new_lo (w_new_lo),
        .o_we     (w_we)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= MDU_NOP;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (w_is_mult || w_is_div)) begin
                        r_op    <= mdu_op;
                        r_a     <= A;
                        r_b     <= B;
                        r_cnt   <= w_ncyc;
                        r_state <= S_RUN;
                    end else if (mdu_op == MDU_MTHI) begin
                        r_hi <= A;
                    end else if (mdu_op == MDU_MTLO) begin
                        r_lo <= A;
                    end
                end
                default: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_IDLE;
                        if (w_we) begin
                            r_hi <= w_new_hi;
                            r_lo <= w_new_lo;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_comb begin
        rd_data = 32'b0;
        if (mdu_op == MDU_MFHI)      rd_data = r_hi;
        else if (mdu_op == MDU_MFLO) rd_data = r_lo;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {HI,LO} queued at launch, compared when busy falls.
module tb_mdu_ctrl;
    import mdu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] sb_q[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 200) begin
            cyc++;
            tick();
        end
    endtask

    task automatic mt(input logic [31:0] h, input logic [31:0] l);
        mdu_op = MDU_MTHI; A = h; tick();
        mdu_op = MDU_MTLO; A = l; tick();
        mdu_op = MDU_NOP;
    endtask

    // Launch, scramble the inputs to prove operand latching, then compare at busy fall.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int ncyc, input string tag);
        int c;
        mdu_op = op; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0; mdu_op = MDU_NOP; A = $urandom; B = $urandom;
        sb_q.push_back(exp);
        wait_idle(c);
        chk({tag, "_cyc"}, 64'(c), 64'(ncyc));
        chk(tag, {hi, lo}, sb_q.pop_front());
    endtask

    initial begin
        int c;
        logic [31:0] ra, rb;
        logic [63:0] e;

        reset = 1'b1; start = 1'b0; mdu_op = MDU_NOP; A = '0; B = '0;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_rd", 64'(rd_data), 64'd0);
        reset = 1'b0;
        mdu_op = MDU_MFHI; #1;
        chk("rst_mfhi", 64'(rd_data), 64'd0);

        mt(32'h1234, 32'h5678);
        chk("mt_hilo", {hi, lo}, {32'h1234, 32'h5678});
        mdu_op = MDU_MFLO; #1; chk("mflo", 64'(rd_data), 64'h5678);
        mdu_op = MDU_MFHI; #1; chk("mfhi", 64'(rd_data), 64'h1234);
        mdu_op = MDU_NOP;  #1; chk("rd_nop", 64'(rd_data), 64'd0);

        mdu_op = MDU_MTHI; A = 32'h0000_4321; start = 1'b1;
        tick();
        start = 1'b0; mdu_op = MDU_NOP;
        chk("mthi_start_busy", 64'(busy), 64'd0);
        chk("mthi_start_hi", 64'(hi), 64'h4321);

        launch(MDU_MULT, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 5, "mult");
        launch(MDU_DIV,  32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, "div");
        launch(MDU_DIV,  32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 10, "div_negb");
        launch(MDU_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, 10, "divu");

        mt(32'h1234, 32'h5678);
        launch(MDU_DIVU, 32'd5, 32'd0, {32'h1234, 32'h5678}, 10, "div0");

        // Busy guards: MTHI and a second MULT while busy must both be dropped.
        mdu_op = MDU_MULT; A = 32'd3; B = 32'd4; start = 1'b1;
        tick();
        sb_q.push_back({32'd0, 32'd12});
        start = 1'b0; mdu_op = MDU_MTHI; A = 32'hAAAA_0000;
        tick();
        mdu_op = MDU_MULT; A = 32'd7; B = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; mdu_op = MDU_MFHI; #1;
        chk("busy_mfhi_old", 64'(rd_data), 64'h1234);
        chk("busy_still", 64'(busy), 64'd1);
        mdu_op = MDU_NOP;
        wait_idle(c);
        chk("guard_cyc", 64'(c), 64'd3);
        chk("guard_hilo", {hi, lo}, sb_q.pop_front());
        tick();
        chk("guard_no_relaunch", 64'(busy), 64'd0);

        // Reset sampled at the edge ending the third busy cycle.
        mdu_op = MDU_MULT; A = 32'd5; B = 32'd5; start = 1'b1;
        tick();
        start = 1'b0; mdu_op = MDU_NOP;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'hFFFF_FFFE}, 5, "multu");

        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            e = {32'b0, ra} * {32'b0, rb};
            launch(MDU_MULTU, ra, rb, e, 5, "rnd_multu");
            rb = $urandom_range(1, 65535);
            e = {ra % rb, ra / rb};
            launch(MDU_DIVU, ra, rb, e, 10, "rnd_divu");
        end

        mt(32'h0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        launch(MDU_MADDU, 32'd1, 32'd1, {32'd1, 32'd0}, 5, "maddu");
        launch(MDU_MSUB, 32'hFFFF_FFFF, 32'd1, {32'd1, 32'd1}, 5, "msub");
`else
        mdu_op = MDU_MADDU; A = 32'd1; B = 32'd1; start = 1'b1;
        tick();
        start = 1'b0; mdu_op = MDU_NOP;
        chk("maddu_off_busy", 64'(busy), 64'd0);
        tick();
        chk("maddu_off_hilo", {hi, lo}, {32'h0, 32'hFFFF_FFFF});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the five-stage pipeline. It sits beside the ALU in the E stage. It accepts one multiply or divide launch at a time and holds `busy` for a fixed latency so the hazard unit can stall later MDU instructions. At the end of that latency it commits the result to the HI/LO architectural registers. It also serves `mthi`/`mtlo` writes and `mfhi`/`mflo` reads.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for multiply-class ops (≥1).
- `DIV_CYCLES`, default 10: busy cycles for divide ops (≥1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high. Clears all state.
- `start`  in  1: launch qualifier from the E stage. Meaningful only for mult/div-class ops.
- `mdu_op`  in  4: operation code.
- `A`  in  32: rs operand.
- `B`  in  32: rt operand.
- `busy`  out  1: high while an operation is in flight.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.
- `rd_data`  out  32: combinational. Equals `hi` when `mdu_op`=MFHI, `lo` when MFLO, 0 otherwise.

## Operation
- Opcodes:
  - NOP 0000
  - MULT 0001, MULTU 0010
  - DIV 0011, DIVU 0100
  - MTHI 0101, MTLO 0110
  - MFHI 0111, MFLO 1000
  - MADD 1001, MADDU 1010, MSUB 1011, MSUBU 1100
  - All other codes behave as NOP.
- States:
  - IDLE (busy=0). In IDLE with `start`=1 and a mult/div-class op, latch A, B and op, load the counter, and go to RUN.
  - RUN (busy=1). The counter decrements each cycle. On the cycle where counter==1, HI/LO are written and the state returns to IDLE.
- Arithmetic:
  - MULT: signed 32×32 multiply to a 64-bit product; {HI,LO} = product.
  - MULTU: unsigned 32×32 multiply to a 64-bit product; {HI,LO} = product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
  - MADD/MSUB: {HI,LO} = {HI,LO} ± signed product, taking HI/LO as they are at commit time, modulo 2^64.
  - MADDU/MSUBU: same as MADD/MSUB, but with the unsigned product.
- Divide by zero (B==0): runs the full DIV_CYCLES, then leaves HI/LO unchanged.
- MTHI/MTLO: write A to HI or LO at the next edge, only in IDLE. `start` is ignored for these ops.
- While busy=1:
  - `start` is ignored.
  - MTHI/MTLO are ignored. The hazard unit guarantees neither is issued; the ignore is a defensive behaviour.
- MFHI/MFLO: always return the current register value. While busy=1 this is the pre-commit value; the hazard unit stalls such reads.
- Reset mid-operation: the operation is aborted, the state goes to IDLE, and HI=LO=0.

## Timing
- Reset values: busy=0, hi=0, lo=0, counter=0, state IDLE. rd_data=0 unless the op is MFHI/MFLO.
- Launch: `start` sampled high at edge t.
  - busy=1 for the N cycles following edge t, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO hold the new value after edge t+N, the same edge at which busy falls.
- Back-to-back: a new `start` is accepted in the first cycle busy=0. The minimum launch spacing is N+1 cycles.
- MTHI/MTLO latency is 1 cycle.
- Reset takes priority over every other event in the same cycle.
- Operand latching: A, B and op are captured at launch. Later input changes during RUN have no effect.

## Configuration
- `MDU_MADD_EN` defined: MADD, MADDU, MSUB and MSUBU are decoded and use MULT_CYCLES.
- `MDU_MADD_EN` not defined: those four codes are treated as NOP. `start` with them is ignored, and busy stays 0.

## Structure
- Shared package / header `mdu_defs`: the opcode constants (MDU_NOP … MDU_MSUBU) and the opcode width of 4. The decoder and hazard unit include the same definitions.
- One sub-module is natural: `mdu_core`. It is a purely combinational 64-bit result generator (mult/div/accumulate) taking {op, A, B, HI, LO} and returning {new_hi, new_lo, write_en}.
- `mdu_ctrl` owns the FSM, counter, operand latches, HI/LO registers and read mux.

## Test plan
- Signed multiply: MULT with A=0xFFFFFFFD (−3), B=5 and start pulse → busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Signed divide: DIV with A=0xFFFFFFF9 (−7), B=2 → busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU: A=7, B=2 → LO=3, HI=1.
- Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIVU with B=0 → busy high for 10 cycles; HI=0x1234 and LO=0x5678 are unchanged afterwards.
- Busy guards: MTHI A=0xAAAA0000 and a second MULT start while busy → both ignored; final HI/LO match the first MULT only; MFHI during busy returns the old HI.
- Reset mid-operation: reset asserted on the 3rd busy cycle of a MULT → next cycle busy=0 and HI=LO=0; a fresh MULTU 0xFFFFFFFF×2 then yields HI=1, LO=0xFFFFFFFE.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 → HI=1, LO=0. Without the macro, the same op leaves busy=0 and HI/LO unchanged.
